// File: rtl/fan_emulator.sv
// Fan-side emulator: measures PWM duty per fan over 1536-clock windows and
// drives a tach line whose toggle rate follows the measured duty.
module fan_emulator #(
  parameter int NUM_FANS = 3
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  input  logic                wb_we_i,
  input  logic [15:0]         wb_adr_i,
  input  logic [15:0]         wb_dat_i,
  output logic [15:0]         wb_dat_o,
  output logic                wb_ack_o,
  input  logic [NUM_FANS-1:0] pwm_in,
  output logic [NUM_FANS-1:0] tach_out
);

  localparam int          DUTY_W    = 9;
  localparam int          ACC_W     = 27;
  localparam logic [15:0] DIV_RST   = 16'd41667;
  localparam logic [15:0] ADR_DIV   = 16'd3;
  localparam logic [15:0] ADR_STALL = 16'd4;

  // One accumulate step: returns {toggle, next accumulator}.
  function automatic logic [ACC_W:0] tach_step(input logic [ACC_W-1:0]  acc_cur,
                                               input logic [DUTY_W-1:0] duty_cur,
                                               input logic [ACC_W-1:0]  thr);
    logic [ACC_W-1:0] sum;
    sum = acc_cur + ACC_W'(duty_cur);
    if (sum >= thr) return {1'b1, sum - thr};
    else            return {1'b0, sum};
  endfunction

  logic [NUM_FANS-1:0] pwm_p0, pwm_p1;
  logic [2:0]          presc;
  logic [7:0]          samp_cnt;
  logic                samp_vld;
  logic [DUTY_W-1:0]   high_cnt [NUM_FANS];
  logic [DUTY_W-1:0]   duty     [NUM_FANS];
  logic [ACC_W-1:0]    acc      [NUM_FANS];
  logic [ACC_W-1:0]    acc_nxt  [NUM_FANS];
  logic [NUM_FANS-1:0] tach_tog;
  logic [ACC_W-1:0]    tach_thr;
  logic [15:0]         tach_div;
  logic [NUM_FANS-1:0] stall, stall_nxt;
  logic                wb_req;
  logic [15:0]         adr_q, dat_q;
  logic                we_q;
  logic                wr_div, wr_stall;
  logic [15:0]         rd_data;

  // Stage p0/p1: two-flop synchroniser on the asynchronous PWM inputs
  always_ff @(posedge wb_clk_i) begin
    pwm_p0 <= pwm_in;
    pwm_p1 <= pwm_p0;
  end

  assign samp_vld = (presc == 3'd5);

  // Duty measurement: one sample every 6 clocks, 256 samples per window
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      presc    <= '0;
      samp_cnt <= '0;
      for (int i = 0; i < NUM_FANS; i++) begin
        high_cnt[i] <= '0;
        duty[i]     <= '0;
      end
    end else if (samp_vld) begin
      presc    <= '0;
      samp_cnt <= samp_cnt + 8'd1;
      for (int i = 0; i < NUM_FANS; i++) begin
        if (samp_cnt == 8'd255) begin
          duty[i]     <= high_cnt[i] + DUTY_W'(pwm_p1[i]);
          high_cnt[i] <= '0;
        end else begin
          high_cnt[i] <= high_cnt[i] + DUTY_W'(pwm_p1[i]);
        end
      end
    end else begin
      presc <= presc + 3'd1;
    end
  end

  // Wishbone: request registered, acked one cycle later; write commits on ack
  assign wb_req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_div   = wb_ack_o & we_q & (adr_q == ADR_DIV);
  assign wr_stall = wb_ack_o & we_q & (adr_q == ADR_STALL);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_FANS; i++) begin
      if (wb_adr_i == 16'(i)) rd_data = 16'(duty[i]);
    end
    if (wb_adr_i == ADR_DIV)   rd_data = tach_div;
    if (wb_adr_i == ADR_STALL) rd_data = 16'(stall);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
    end else begin
      wb_ack_o <= wb_req;
      if (wb_req) begin
        wb_dat_o <= rd_data;
        adr_q    <= wb_adr_i;
        dat_q    <= wb_dat_i;
        we_q     <= wb_we_i;
      end
    end
  end

  // The new stall value acts on the same edge it is written, so the tach
  // drops on the clock right after the ack cycle.
  assign stall_nxt = wr_stall ? dat_q[NUM_FANS-1:0] : stall;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tach_div <= DIV_RST;
      stall    <= '0;
    end else begin
      if (wr_div) tach_div <= dat_q;
      stall <= stall_nxt;
    end
  end

  // Tach generation: duty-weighted accumulator against {tach_div, 10'b0}
  assign tach_thr = {1'b0, tach_div, 10'b0};

  always_comb begin
    tach_tog = '0;
    for (int i = 0; i < NUM_FANS; i++) begin
      {tach_tog[i], acc_nxt[i]} = tach_step(acc[i], duty[i], tach_thr);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tach_out <= '0;
      for (int i = 0; i < NUM_FANS; i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FANS; i++) begin
        if (stall_nxt[i]) begin
          acc[i]      <= '0;
          tach_out[i] <= 1'b0;
        end else if (wr_div || (tach_div == 16'd0)) begin
          acc[i] <= '0;
        end else begin
          acc[i] <= acc_nxt[i];
          if (tach_tog[i]) tach_out[i] <= ~tach_out[i];
        end
      end
    end
  end

endmodule

// File: doc/fan_emulator.md
Name: fan_emulator

Overview:
- Synthesizable model of the fan end of the fan PWM/tach interface, used for board self-test and closed-loop bench runs of the fan control path.
- Measures the duty cycle of each incoming PWM control line.
- Drives a tach line per fan, with toggle rate proportional to the measured duty.
- Wishbone slave on the monitor bus: measured duty read back, tach scaling set, stall faults injected per fan.

Parameters:
- NUM_FANS, 3, number of emulated fans; register map below is fixed for 3.

Ports:
- wb_clk_i  in  1  system clock (40 MHz nominal)
- wb_rst_i  in  1  reset
- wb_stb_i  in  1  wishbone strobe
- wb_cyc_i  in  1  wishbone cycle
- wb_we_i  in  1  wishbone write enable
- wb_adr_i  in  16  wishbone word address
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data
- wb_ack_o  out  1  wishbone acknowledge
- pwm_in  in  NUM_FANS  PWM control from the fan controller, asynchronous
- tach_out  out  NUM_FANS  emulated tach signals

Behaviour:
- Clocking/reset:
  - Single clock wb_clk_i; reset wb_rst_i is synchronous, active-high.
  - Reset values: wb_ack_o=0, wb_dat_o=0, tach_out=0, duty regs=0, accumulators=0, window counters=0, tach_div=16'd41667, stall=0.
- Wishbone:
  - A request is cyc&stb&~ack; wb_ack_o is asserted the following cycle for exactly one cycle.
  - A held request is therefore acked every other cycle.
  - Read data is valid with ack and selected by the address latched at request.
  - Writes take effect on the ack cycle.
  - Map (full 16-bit decode):
    - 0..2 duty_n, RO, {7'b0, duty[8:0]}
    - 3 tach_div, RW, 16 bits
    - 4 stall, RW, bits[2:0]
    - any other address: reads 0, writes ignored, still acked.
- Input sync:
  - Each pwm_in bit passes through a 2-flop synchroniser.
  - Measurement sees a 2-cycle delay.
- Duty measurement (shared timebase):
  - Prescaler counts 0..5.
  - A sample is taken when the prescaler is 5, i.e. every 6 clocks.
  - An 8-bit sample counter runs 0..255 and wraps; one window = 256 samples = 1536 clocks.
  - Per fan, a 9-bit high_count increments on each high sample.
  - On sample 255: duty_n <= high_count + current sample (range 0..256), and high_count <= 0.
  - duty_n updates once per window only and holds between windows.
- Tach generation (per fan):
  - Threshold = {tach_div, 10'b0}.
  - Accumulator is 27 bits so it cannot overflow.
  - Each clock, when tach_div!=0 and stall[n]==0: sum = acc + duty_n.
    - If sum >= threshold: acc <= sum - threshold and tach_out[n] toggles.
    - Otherwise acc <= sum.
  - At duty 256, tach half-period = 4*tach_div clocks.
  - Default tach_div gives 166668 clocks, about 60 rising edges per 0.5 s at 40 MHz.
  - duty_n=0: accumulator holds and tach_out holds its current level.
  - tach_div=0: accumulator cleared, tach_out holds its level.
  - Write to tach_div: all accumulators cleared on the write cycle; tach levels are unchanged.
- Stall:
  - stall[n]=1 forces tach_out[n]=0 from the next clock and holds acc_n at 0.
  - On clearing stall[n], accumulation restarts from 0 with tach low.
- Reset mid-window: discards the partial window; the first duty update comes 1536 clocks after reset deasserts.

Test Plan:
- Reset, then read addresses 0..4 and 7 -> 0,0,0,41667,0,0; each ack is a single cycle, one cycle after the request.
- pwm_in=3'b111 constant, tach_div=64:
  - after first full window, duty_0..2 read 256;
  - tach_out toggles every 256 clocks;
  - duty value and tach toggle behaviour are unchanged across the sample-counter wrap.
- pwm_in[0] driven by a 6-clk-prescaled 8-bit counter compared <128, tach_div=64:
  - duty_0 reads 128 ±1;
  - tach_out[0] half-period averages 512 clocks.
- pwm_in[1]=0 -> duty_1 reads 0 and tach_out[1] holds its level indefinitely.
  - Then pwm_in[1]=1 -> toggling resumes after the next window.
- Write stall=3'b010 -> tach_out[1] low next clock, others unaffected.
  - Write stall=0 -> first toggle of tach_out[1] after 4*tach_div clocks (at duty 256).
- Write tach_div=0 mid-run -> all tach levels freeze.
  - Write tach_div=64 -> toggling restarts from a cleared accumulator.
  - Assert reset mid-window -> all outputs return to their reset values.
